// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RISC-V-subset datapath: fetch, decode, execute, memory, writeback.
// Latency: Moore outputs decoded from the registered state; only FETCH strobes and pc_write in BRANCH are qualified by mem_ready/zero.
// Backpressure: memory phases hold their request until mem_ready; reset blanks every strobe in the same cycle.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WR   = 4'd4,
    WB_LD    = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t cur_state;
  state_t nxt_state;
  logic   retire;

  assign state = cur_state;

  // An instruction retires on the edge that leaves its last state.
  assign retire = (cur_state == WB_LD) || (cur_state == WB_R) || (cur_state == BRANCH) ||
                  ((cur_state == MEM_WR) && mem_ready);

  // Next-state selection; undefined encodings fall into TRAP.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      FETCH:    if (mem_ready) nxt_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:              nxt_state = EXEC_R;
          OP_LOAD, OP_STORE: nxt_state = MEM_ADDR;
          OP_BEQ:            nxt_state = BRANCH;
          default:           nxt_state = TRAP;
        endcase
      end
      MEM_ADDR: begin
        // IR is only written in FETCH, so the opcode is still the one decoded.
        if (opcode == OP_LOAD)       nxt_state = MEM_RD;
        else if (opcode == OP_STORE) nxt_state = MEM_WR;
        else                         nxt_state = TRAP;
      end
      MEM_RD:   if (mem_ready) nxt_state = WB_LD;
      MEM_WR:   if (mem_ready) nxt_state = FETCH;
      WB_LD:    nxt_state = FETCH;
      EXEC_R:   nxt_state = WB_R;
      WB_R:     nxt_state = FETCH;
      BRANCH:   nxt_state = FETCH;
      TRAP:     nxt_state = TRAP;
      default:  nxt_state = TRAP;
    endcase
  end

  // State register, sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state == TRAP) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Datapath strobes and mux selects decoded from the current state.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 2'b01;
        aluop     = 2'b10;
      end
      WB_R:     reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b01;
        aluop     = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
    // An aborted instruction must not touch memory, IR, PC or registers.
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control with a narrow retired counter so wrap-around is reachable.
// Each instruction is expanded into its expected state trace with random memory waits.
// Outputs are compared against the per-state control table every cycle.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic             reg_write, mem_to_reg;
  logic [1:0]       alu_src_a, alu_src_b, aluop;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [13:0]      obs;
  logic [4:0]       strobes;

  int checks = 0;
  int passes = 0;
  int model_retired = 0;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .state(state),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
                alu_src_a, alu_src_b, aluop};
  assign strobes = {mem_read, mem_write, ir_write, pc_write, reg_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Control table: {mr, mw, iord, irw, pcw, pcsrc, rw, m2r, a, b, aluop}
  function automatic logic [13:0] exp_outs(input int st, input logic rdy, input logic z);
    logic mr, mw, io, irw, pcw, pcs, rw, m2r;
    logic [1:0] a, b, op;
    {mr, mw, io, irw, pcw, pcs, rw, m2r} = 8'b0;
    a = 2'b00; b = 2'b00; op = 2'b00;
    case (st)
      0: begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      1: begin a = 2'b10; b = 2'b10; end
      2: begin a = 2'b01; b = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin mw = 1; io = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin a = 2'b01; op = 2'b10; end
      7: rw = 1;
      8: begin a = 2'b01; op = 2'b01; pcs = 1; pcw = z; end
      default: ;
    endcase
    return {mr, mw, io, irw, pcw, pcs, rw, m2r, a, b, op};
  endfunction

  // One clock cycle: drive mem_ready, check outputs mid-cycle, advance past the edge.
  task automatic step(input int exp_st, input logic rdy);
    mem_ready = rdy;
    @(negedge clk);
    check("state", 32'(state), 32'(exp_st));
    check("outputs", 32'(obs), 32'(exp_outs(exp_st, rdy, zero)));
    check("illegal", 32'(illegal), 32'(exp_st == 9));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_strobes", 32'(strobes), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_retired = 0;
    check("reset_state", 32'(state), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
  endtask

  // kind: 0 R-type, 1 load, 2 store, 3 beq
  task automatic run_instr(input int kind, input logic z, input int wf, input int wm);
    case (kind)
      0: opcode = 7'b0110011;
      1: opcode = 7'b0000011;
      2: opcode = 7'b0100011;
      default: opcode = 7'b1100011;
    endcase
    zero = z;
    repeat (wf) step(0, 1'b0);
    step(0, 1'b1);
    step(1, rbit());
    case (kind)
      0: begin step(6, rbit()); step(7, rbit()); end
      1: begin step(2, rbit()); repeat (wm) step(3, 1'b0); step(3, 1'b1); step(5, rbit()); end
      2: begin step(2, rbit()); repeat (wm) step(4, 1'b0); step(4, 1'b1); end
      default: step(8, rbit());
    endcase
    model_retired++;
    check("retired", 32'(retired), 32'(model_retired % (1 << CNT_W)));
    check("back_to_fetch", 32'(state), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    opcode = 7'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    do_reset();

    // Directed instructions from the test plan.
    run_instr(0, 1'b0, 0, 0);
    run_instr(1, 1'b1, 0, 2);
    run_instr(2, 1'b0, 0, 0);
    run_instr(3, 1'b1, 0, 0);
    run_instr(3, 1'b0, 1, 0);

    // Illegal opcode traps and stays there quietly.
    opcode = 7'b1111111;
    step(0, 1'b1);
    step(1, rbit());
    repeat (10) step(9, rbit());
    do_reset();

    // Reset while a load waits in MEM_RD.
    opcode = 7'b0000011;
    step(0, 1'b1);
    step(1, 1'b1);
    step(2, 1'b1);
    step(3, 1'b0);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state), 32'd3);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_next_state", 32'(state), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    model_retired = 0;

    // Random mix past the 4-bit counter wrap.
    for (int i = 0; i < 24; i++) begin
      run_instr(int'($urandom_range(0, 3)), rbit(), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RISC-V-subset datapath. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit aluop consumed by the ALU control decoder: 00 add, 01 sub/compare, 10 R-type funct decode.
- Owns all datapath strobes and mux selects, and handshakes with a shared instruction/data memory through a ready signal.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  instruction register bits [6:0].
- zero  input  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  input  1  memory completes the pending read or write this cycle.
- mem_read  output  1  memory read request, held until mem_ready.
- mem_write  output  1  memory write request, held until mem_ready.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load the instruction register.
- pc_write  output  1  load the PC.
- pc_src  output  1  PC source: 0 = ALU result (PC+4), 1 = ALUOut (branch target).
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = memory data register.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- aluop  output  2  to the ALU control decoder.
- state  output  4  current state encoding, for debug.
- illegal  output  1  sticky illegal-opcode flag.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM. Registered state; outputs are decoded from state, plus the mem_ready/zero qualifications listed below.
- Every output not listed for a state is 0.
- Reset has priority over every transition:
  - state <= FETCH, illegal <= 0, retired <= 0.
  - During any cycle with reset=1, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write) are forced to 0.
  - Reset mid-instruction aborts it with no further strobes.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WR=4, WB_LD=5, EXEC_R=6, WB_R=7, BRANCH=8, TRAP=9.
- FETCH:
  - Outputs: mem_read=1, iord=0, a=00, b=01, aluop=00.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: a=10, b=10, aluop=00 (branch target precomputed into ALUOut).
  - opcode 0110011 -> EXEC_R.
  - opcode 0000011 or 0100011 -> MEM_ADDR.
  - opcode 1100011 -> BRANCH.
  - Any other opcode -> TRAP.
- MEM_ADDR:
  - Outputs: a=01, b=10, aluop=00.
  - Load -> MEM_RD; store -> MEM_WR. The opcode is stable because the IR is only written in FETCH.
- MEM_RD:
  - Outputs: mem_read=1, iord=1.
  - mem_ready=1 -> WB_LD; otherwise stay.
- WB_LD:
  - Outputs: reg_write=1, mem_to_reg=1.
  - Next state FETCH; retire.
- MEM_WR:
  - Outputs: mem_write=1, iord=1.
  - mem_ready=1 -> FETCH and retire; otherwise stay.
- EXEC_R:
  - Outputs: a=01, b=00, aluop=10.
  - Next state WB_R.
- WB_R:
  - Outputs: reg_write=1, mem_to_reg=0.
  - Next state FETCH; retire.
- BRANCH:
  - Outputs: a=01, b=00, aluop=01, pc_src=1, pc_write=zero.
  - Next state FETCH; retire whether taken or not.
- TRAP:
  - Outputs: illegal=1; all strobes 0.
  - Stays in TRAP until reset.
- Retire rule:
  - retired increments by 1 on the clock edge leaving a final state (WB_LD, WB_R, BRANCH, or MEM_WR with mem_ready).
  - Wraps modulo 2^CNT_W with no saturation.
- Latency with mem_ready tied high:
  - R-type 4 cycles.
  - Load 5 cycles.
  - Store 4 cycles.
  - Branch 3 cycles.
  - Each wait cycle on mem_ready adds exactly 1 cycle.
- mem_read and mem_write are never both 1. At most one of ir_write, reg_write or mem_write is 1 in any cycle.
- State values 10-15 are unreachable. If entered, they must go to TRAP.

Test Plan:
- Reset, then R-type (opcode 0110011) with mem_ready=1:
  - state sequence 0,1,6,7,0.
  - aluop=10 in EXEC_R; reg_write=1 only in WB_R.
  - retired 0->1.
- Load (0000011) with mem_ready low for 2 cycles in MEM_RD:
  - sequence 0,1,2,3,3,3,5,0.
  - mem_read and iord held 1 through all MEM_RD cycles.
  - mem_to_reg=1 and reg_write=1 in WB_LD; total 7 cycles.
- Store (0100011):
  - sequence 0,1,2,4,0.
  - mem_write=1 only in MEM_WR; reg_write stays 0 throughout.
  - retired increments once.
- Beq (1100011):
  - zero=1: pc_write=1, pc_src=1, aluop=01 in BRANCH.
  - Repeat with zero=0: pc_write=0 in BRANCH.
  - Both cases take 3 cycles and retire.
- Opcode 1111111:
  - DECODE -> TRAP; illegal=1 held for 10 cycles with no strobes.
  - Reset returns state=0, illegal=0, retired=0.
- Reset asserted in MEM_RD while mem_ready=0:
  - next state FETCH; mem_read=0 during the reset cycle; retired unchanged at 0.
  - Then preload near overflow (CNT_W=4, 15 instructions) and confirm the 16th instruction wraps retired to 0.
